// File: rtl/bat_bus_pkg.sv
// Shared definitions for the bus transfer controller: FSM encoding, default
// bus width and the REG_RW direction encoding.
package bat_bus_pkg;

  localparam int unsigned BAT_BUS_WIDTH = 16;

  localparam logic BUS_RW_DRIVE = 1'b1;
  localparam logic BUS_RW_LATCH = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } bat_state_e;

endpackage

// File: rtl/bus_sel_decoder.sv
// Turns a register index plus a valid bit into a one-hot enable vector;
// indices at or beyond NUM_REGS decode to all zeros.
module bus_sel_decoder #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned SEL_WIDTH = 3
) (
  input  logic [SEL_WIDTH-1:0] idx_i,
  input  logic                 valid_i,
  output logic [NUM_REGS-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot_o[i] = valid_i && (idx_i == SEL_WIDTH'(i));
    end
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Initiator for the shared tri-state register bus: sequences source/destination
// strobes for one move at a time. Optional debug snoop port: BUS_TRANSFER_SNOOP_EN.
module bus_transfer_ctrl
  import bat_bus_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = BAT_BUS_WIDTH,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned SEL_WIDTH = 3
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 REQ,
  input  logic [SEL_WIDTH-1:0] SRC_SEL,
  input  logic                 SRC_IMM,
  input  logic [BUS_WIDTH-1:0] IMM,
  input  logic [SEL_WIDTH-1:0] DST_SEL,
  output logic                 BUSY,
  output logic                 ACK,
  output logic                 ERR,
  output logic [NUM_REGS-1:0]  REG_ENABLE,
  output logic [NUM_REGS-1:0]  REG_RW,
`ifdef BUS_TRANSFER_SNOOP_EN
  output logic [BUS_WIDTH-1:0] SNOOP_DATA,
  output logic                 SNOOP_VALID,
`endif
  inout  wire  [BUS_WIDTH-1:0] DATA
);

  localparam int unsigned CMP_W = SEL_WIDTH + 1;
  localparam logic [CMP_W-1:0] NUM_REGS_C = CMP_W'(NUM_REGS);

  bat_state_e state_q, state_d;

  logic [SEL_WIDTH-1:0] src_q, dst_q;
  logic                 src_imm_q;
  logic [BUS_WIDTH-1:0] imm_q;

  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] en_q, en_d;
  logic [NUM_REGS-1:0] rw_q, rw_d;

  logic                 latch_c;
  logic                 in_idle_c;
  logic [SEL_WIDTH-1:0] src_eff_c, dst_eff_c;
  logic                 src_imm_eff_c;
  logic                 req_err_c;
  logic [NUM_REGS-1:0]  src_oh_c, dst_oh_c;
  logic                 drive_imm_c;

  // Selects come straight from the inputs on the IDLE->SETUP edge, from the latches afterwards.
  assign in_idle_c     = (state_q == ST_IDLE);
  assign src_eff_c     = in_idle_c ? SRC_SEL : src_q;
  assign dst_eff_c     = in_idle_c ? DST_SEL : dst_q;
  assign src_imm_eff_c = in_idle_c ? SRC_IMM : src_imm_q;

  assign req_err_c = ({1'b0, DST_SEL} >= NUM_REGS_C) ||
                     (!SRC_IMM && (({1'b0, SRC_SEL} >= NUM_REGS_C) || (SRC_SEL == DST_SEL)));

  bus_sel_decoder #(
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_src_dec (
    .idx_i    (src_eff_c),
    .valid_i  (!src_imm_eff_c),
    .onehot_o (src_oh_c)
  );

  bus_sel_decoder #(
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_dst_dec (
    .idx_i    (dst_eff_c),
    .valid_i  (1'b1),
    .onehot_o (dst_oh_c)
  );

  // Next state, plus the output values that the next state will present.
  always_comb begin
    state_d = state_q;
    latch_c = 1'b0;
    busy_d  = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    en_d    = '0;
    rw_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          latch_c = 1'b1;
          state_d = req_err_c ? ST_ERROR : ST_SETUP;
        end
      end
      ST_SETUP:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      ST_ERROR:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_SETUP: begin
        busy_d = 1'b1;
        en_d   = src_oh_c;
      end
      ST_CAPTURE: begin
        busy_d = 1'b1;
        en_d   = src_oh_c | dst_oh_c;
      end
      ST_DONE: begin
        busy_d = 1'b1;
        ack_d  = 1'b1;
      end
      ST_ERROR: err_d = 1'b1;
      default: ;
    endcase

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      rw_d[i] = (en_d[i] && src_oh_c[i]) ? BUS_RW_DRIVE : BUS_RW_LATCH;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      src_imm_q <= 1'b0;
      imm_q     <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      en_q      <= '0;
      rw_q      <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      if (latch_c) begin
        src_q     <= SRC_SEL;
        dst_q     <= DST_SEL;
        src_imm_q <= SRC_IMM;
        imm_q     <= IMM;
      end
    end
  end

  assign BUSY       = busy_q;
  assign ACK        = ack_q;
  assign ERR        = err_q;
  assign REG_ENABLE = en_q;
  assign REG_RW     = rw_q;

  // Decoded from registered state only, so an async reset releases the bus at once.
  assign drive_imm_c = src_imm_q && ((state_q == ST_SETUP) || (state_q == ST_CAPTURE));
  assign DATA        = drive_imm_c ? imm_q : {BUS_WIDTH{1'bz}};

`ifdef BUS_TRANSFER_SNOOP_EN
  logic [BUS_WIDTH-1:0] snoop_data_q;
  logic                 snoop_valid_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      snoop_data_q  <= '0;
      snoop_valid_q <= 1'b0;
    end else begin
      snoop_valid_q <= ack_d;
      if (state_q == ST_CAPTURE) begin
        snoop_data_q <= DATA;
      end
    end
  end

  assign SNOOP_DATA  = snoop_data_q;
  assign SNOOP_VALID = snoop_valid_q;
`endif

  a_single_reg_driver : assert property (@(posedge CLOCK) disable iff (!RESET)
    $onehot0(en_q & rw_q));

  a_no_bus_contention : assert property (@(posedge CLOCK) disable iff (!RESET)
    !(drive_imm_c && |(en_q & rw_q)));

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for bus_transfer_ctrl with a six-register bus model.
module tb_bus_transfer_ctrl;

  localparam int unsigned BW = 16;
  localparam int unsigned NR = 6;
  localparam int unsigned SW = 3;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          REQ;
  logic [SW-1:0] SRC_SEL;
  logic          SRC_IMM;
  logic [BW-1:0] IMM;
  logic [SW-1:0] DST_SEL;
  logic          BUSY;
  logic          ACK;
  logic          ERR;
  logic [NR-1:0] REG_ENABLE;
  logic [NR-1:0] REG_RW;
  wire  [BW-1:0] DATA;
`ifdef BUS_TRANSFER_SNOOP_EN
  logic [BW-1:0] SNOOP_DATA;
  logic          SNOOP_VALID;
`endif

  logic [BW-1:0] regs [NR];
  logic          clr;
  logic          reg_drive;
  logic [BW-1:0] reg_drv_val;
  int unsigned   cyc;
  int unsigned   last_ack;
  int            n_vec;
  int            n_miss;

  bus_transfer_ctrl #(
    .BUS_WIDTH (BW),
    .NUM_REGS  (NR),
    .SEL_WIDTH (SW)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .REQ         (REQ),
    .SRC_SEL     (SRC_SEL),
    .SRC_IMM     (SRC_IMM),
    .IMM         (IMM),
    .DST_SEL     (DST_SEL),
    .BUSY        (BUSY),
    .ACK         (ACK),
    .ERR         (ERR),
    .REG_ENABLE  (REG_ENABLE),
    .REG_RW      (REG_RW),
`ifdef BUS_TRANSFER_SNOOP_EN
    .SNOOP_DATA  (SNOOP_DATA),
    .SNOOP_VALID (SNOOP_VALID),
`endif
    .DATA        (DATA)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Bidirectional register file attached to the bus
  always_comb begin
    reg_drive   = 1'b0;
    reg_drv_val = '0;
    for (int i = 0; i < int'(NR); i++) begin
      if (REG_ENABLE[i] && REG_RW[i]) begin
        reg_drive   = 1'b1;
        reg_drv_val = regs[i];
      end
    end
  end

  assign DATA = reg_drive ? reg_drv_val : {BW{1'bz}};

  always @(posedge CLOCK) begin
    for (int i = 0; i < int'(NR); i++) begin
      if (clr) regs[i] <= '0;
      else if (REG_ENABLE[i] && !REG_RW[i]) regs[i] <= DATA;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input logic [SW-1:0] i);
    logic [NR-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // One valid move; gap adds the IDLE cycle that follows a held-REQ transfer.
  task automatic xfer(input string tag, input logic imm_f, input logic [SW-1:0] src,
                      input logic [BW-1:0] imm, input logic [SW-1:0] dst,
                      input logic [BW-1:0] exp_val, input bit hold, input bit gap,
                      input bit chk_space);
    logic [NR-1:0] s_oh;
    s_oh    = imm_f ? '0 : oh(src);
    REQ     = 1'b1;
    SRC_IMM = imm_f;
    SRC_SEL = src;
    IMM     = imm;
    DST_SEL = dst;
    if (gap) begin
      @(negedge CLOCK);
      check_vec({tag, " idle busy"}, 32'(BUSY), 32'(0));
    end
    @(negedge CLOCK);
    check_vec({tag, " setup en"}, 32'(REG_ENABLE), 32'(s_oh));
    check_vec({tag, " setup rw"}, 32'(REG_RW), 32'(s_oh));
    check_vec({tag, " setup busy"}, 32'(BUSY), 32'(1));
    if (imm_f) check_vec({tag, " setup data"}, 32'(DATA), 32'(imm));
    REQ     = hold;
    SRC_SEL = ~src;
    DST_SEL = ~dst;
    IMM     = ~imm;
    SRC_IMM = ~imm_f;
    @(negedge CLOCK);
    check_vec({tag, " capture en"}, 32'(REG_ENABLE), 32'(s_oh | oh(dst)));
    check_vec({tag, " capture rw"}, 32'(REG_RW), 32'(s_oh));
    check_vec({tag, " capture data"}, 32'(DATA), 32'(exp_val));
    check_vec({tag, " capture ack"}, 32'(ACK), 32'(0));
    @(negedge CLOCK);
    check_vec({tag, " done en"}, 32'(REG_ENABLE), 32'(0));
    check_vec({tag, " done ack"}, 32'(ACK), 32'(1));
    check_vec({tag, " done busy"}, 32'(BUSY), 32'(1));
    check_vec({tag, " dest value"}, 32'(regs[dst]), 32'(exp_val));
`ifdef BUS_TRANSFER_SNOOP_EN
    check_vec({tag, " snoop valid"}, 32'(SNOOP_VALID), 32'(1));
    check_vec({tag, " snoop data"}, 32'(SNOOP_DATA), 32'(exp_val));
`endif
    if (chk_space) check_vec({tag, " ack spacing"}, cyc - last_ack, 32'(4));
    last_ack = cyc;
    if (!hold) begin
      @(negedge CLOCK);
      check_vec({tag, " post ack"}, 32'(ACK), 32'(0));
      check_vec({tag, " post busy"}, 32'(BUSY), 32'(0));
    end
  endtask

  task automatic bad_req(input string tag, input logic imm_f, input logic [SW-1:0] src,
                         input logic [SW-1:0] dst);
    logic [BW-1:0] snap [NR];
    snap    = regs;
    REQ     = 1'b1;
    SRC_IMM = imm_f;
    SRC_SEL = src;
    DST_SEL = dst;
    IMM     = 16'hDEAD;
    @(negedge CLOCK);
    check_vec({tag, " err"}, 32'(ERR), 32'(1));
    check_vec({tag, " busy"}, 32'(BUSY), 32'(0));
    check_vec({tag, " en"}, 32'(REG_ENABLE), 32'(0));
    check_vec({tag, " rw"}, 32'(REG_RW), 32'(0));
    REQ = 1'b0;
    @(negedge CLOCK);
    check_vec({tag, " err drop"}, 32'(ERR), 32'(0));
    check_vec({tag, " no ack"}, 32'(ACK), 32'(0));
    check_vec({tag, " en after"}, 32'(REG_ENABLE), 32'(0));
    for (int i = 0; i < int'(NR); i++) begin
      check_vec({tag, " reg keep"}, 32'(regs[i]), 32'(snap[i]));
    end
  endtask

  initial begin
    RESET    = 1'b0;
    REQ      = 1'b0;
    SRC_IMM  = 1'b0;
    SRC_SEL  = '0;
    DST_SEL  = '0;
    IMM      = '0;
    clr      = 1'b1;
    n_vec    = 0;
    n_miss   = 0;
    last_ack = 0;

    repeat (2) @(negedge CLOCK);
    check_vec("reset busy", 32'(BUSY), 32'(0));
    check_vec("reset ack", 32'(ACK), 32'(0));
    check_vec("reset err", 32'(ERR), 32'(0));
    check_vec("reset en", 32'(REG_ENABLE), 32'(0));
    check_vec("reset rw", 32'(REG_RW), 32'(0));
`ifdef BUS_TRANSFER_SNOOP_EN
    check_vec("reset snoop data", 32'(SNOOP_DATA), 32'(0));
    check_vec("reset snoop valid", 32'(SNOOP_VALID), 32'(0));
`endif
    clr   = 1'b0;
    RESET = 1'b1;
    @(negedge CLOCK);

    xfer("imm r3", 1'b1, 3'd0, 16'hBEEF, 3'd3, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    xfer("r3 to r5", 1'b0, 3'd3, 16'h0000, 3'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    xfer("imm r0", 1'b1, 3'd0, 16'h1234, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
    xfer("imm same sel", 1'b1, 3'd4, 16'h0F0F, 3'd4, 16'h0F0F, 1'b0, 1'b0, 1'b0);

    bad_req("src eq dst", 1'b0, 3'd2, 3'd2);
    bad_req("dst 7", 1'b0, 3'd1, 3'd7);
    bad_req("src 6", 1'b0, 3'd6, 3'd1);
    bad_req("imm dst 6", 1'b1, 3'd0, 3'd6);

    xfer("b2b imm r2", 1'b1, 3'd0, 16'hA5A5, 3'd2, 16'hA5A5, 1'b1, 1'b0, 1'b0);
    xfer("b2b r2 to r1", 1'b0, 3'd2, 16'h0000, 3'd1, 16'hA5A5, 1'b1, 1'b1, 1'b1);
    xfer("b2b r0 to r4", 1'b0, 3'd0, 16'h0000, 3'd4, 16'h1234, 1'b0, 1'b1, 1'b1);

    // Reset asserted inside CAPTURE, before its closing edge
    REQ     = 1'b1;
    SRC_IMM = 1'b0;
    SRC_SEL = 3'd0;
    DST_SEL = 3'd2;
    @(negedge CLOCK);
    REQ = 1'b0;
    @(negedge CLOCK);
    check_vec("rst pre en", 32'(REG_ENABLE), 32'(oh(3'd0) | oh(3'd2)));
    #1 RESET = 1'b0;
    #1;
    check_vec("rst en drop", 32'(REG_ENABLE), 32'(0));
    check_vec("rst rw drop", 32'(REG_RW), 32'(0));
    check_vec("rst busy drop", 32'(BUSY), 32'(0));
    @(negedge CLOCK);
    check_vec("rst no ack", 32'(ACK), 32'(0));
    RESET = 1'b1;
    repeat (2) begin
      @(negedge CLOCK);
      check_vec("rst idle ack", 32'(ACK), 32'(0));
      check_vec("rst idle busy", 32'(BUSY), 32'(0));
    end
    check_vec("rst dest kept", 32'(regs[2]), 32'(16'hA5A5));

    xfer("after rst r2 to r3", 1'b0, 3'd2, 16'h0000, 3'd3, 16'hA5A5, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
